// File: rtl/axi_4_master_controller.sv
// axi_4_master_controller
// Turns single VLSU load/store burst requests into AXI4 INCR bursts.
// Reads use AR then R; writes use AW with W running alongside, then B.
// The block counts beats, drives WLAST, checks that RLAST lines up with the
// last beat, and returns done/error pulses to the VLSU.
//
// Ports
//   clk, reset                    clock, synchronous active-high reset
//   ld_req, st_req                VLSU requests (ld_req wins), sampled in IDLE
//   req_addr, req_len             burst start address, beats minus 1
//   st_wdata, st_wdata_valid      store beat from VLSU
//   st_wdata_pop                  store beat taken by the slave
//   ld_data, ld_data_valid/ready  load beat to VLSU
//   ld_done, st_done, resp_err    completion pulses, error qualifier
//   busy                          controller not in IDLE
//   m_ar*/s_arready, s_r*/m_rready                 AXI read channels
//   m_aw*/s_awready, m_w*/s_wready, s_b*/m_bready  AXI write channels
//
// state          | meaning
// S_IDLE         | waiting for ld_req / st_req
// S_RD_ADDR      | AR valid, waiting for s_arready
// S_RD_DATA      | accepting R beats until the latched length is reached
// S_WR_ADDR_DATA | AW valid; W beats flow in parallel
// S_WR_DATA      | AW accepted, remaining W beats
// S_WR_RESP      | waiting for the B response
module axi_4_master_controller #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ld_req,
   input  logic                  st_req,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [LEN_WIDTH-1:0]  req_len,
   input  logic [DATA_WIDTH-1:0] st_wdata,
   input  logic                  st_wdata_valid,
   output logic                  st_wdata_pop,
   output logic [DATA_WIDTH-1:0] ld_data,
   output logic                  ld_data_valid,
   input  logic                  ld_data_ready,
   output logic                  ld_done,
   output logic                  st_done,
   output logic                  resp_err,
   output logic                  busy,
   output logic [ADDR_WIDTH-1:0] m_araddr,
   output logic [LEN_WIDTH-1:0]  m_arlen,
   output logic                  m_arvalid,
   input  logic                  s_arready,
   input  logic [DATA_WIDTH-1:0] s_rdata,
   input  logic [1:0]            s_rresp,
   input  logic                  s_rlast,
   input  logic                  s_rvalid,
   output logic                  m_rready,
   output logic [ADDR_WIDTH-1:0] m_awaddr,
   output logic [LEN_WIDTH-1:0]  m_awlen,
   output logic                  m_awvalid,
   input  logic                  s_awready,
   output logic [DATA_WIDTH-1:0] m_wdata,
   output logic                  m_wlast,
   output logic                  m_wvalid,
   input  logic                  s_wready,
   input  logic [1:0]            s_bresp,
   input  logic                  s_bvalid,
   output logic                  m_bready
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_ADDR,
      S_RD_DATA,
      S_WR_ADDR_DATA,
      S_WR_DATA,
      S_WR_RESP
   } state_t;

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [LEN_WIDTH-1:0]  r_len;
   logic [LEN_WIDTH-1:0]  r_cnt;
   logic                  r_err;
   logic                  r_w_done;

   logic w_final;
   logic w_w_phase;
   logic w_r_hs;
   logic w_r_bad;
   logic w_aw_hs;
   logic w_w_last;

   assign w_final   = (r_cnt == r_len);
   // W may run while AW is pending, but goes quiet once the last beat is taken
   assign w_w_phase = ((r_state == S_WR_ADDR_DATA) && !r_w_done) || (r_state == S_WR_DATA);

   assign m_araddr  = r_addr;
   assign m_arlen   = r_len;
   assign m_awaddr  = r_addr;
   assign m_awlen   = r_len;
   assign m_arvalid = (r_state == S_RD_ADDR);
   assign m_awvalid = (r_state == S_WR_ADDR_DATA);
   assign m_bready  = (r_state == S_WR_RESP);
   assign busy      = (r_state != S_IDLE);

   assign m_rready      = (r_state == S_RD_DATA) && ld_data_ready;
   assign ld_data       = s_rdata;
   assign ld_data_valid = (r_state == S_RD_DATA) && s_rvalid;
   assign w_r_hs        = s_rvalid && m_rready;
   // an early or missing RLAST is an error, but the beat count still decides the end
   assign w_r_bad       = (s_rlast != w_final) || (s_rresp != 2'b00);
   assign ld_done       = w_r_hs && w_final;

   assign m_wvalid     = w_w_phase && st_wdata_valid;
   assign m_wdata      = st_wdata;
   assign m_wlast      = w_w_phase && w_final;
   assign st_wdata_pop = m_wvalid && s_wready;
   assign w_w_last     = st_wdata_pop && w_final;
   assign w_aw_hs      = m_awvalid && s_awready;

   assign st_done  = m_bready && s_bvalid;
   assign resp_err = (ld_done && (r_err || w_r_bad)) ||
                     (st_done && (r_err || (s_bresp != 2'b00)));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_addr   <= '0;
         r_len    <= '0;
         r_cnt    <= '0;
         r_err    <= 1'b0;
         r_w_done <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (ld_req || st_req) begin
                  r_addr   <= req_addr;
                  r_len    <= req_len;
                  r_cnt    <= '0;
                  r_err    <= 1'b0;
                  r_w_done <= 1'b0;
                  r_state  <= ld_req ? S_RD_ADDR : S_WR_ADDR_DATA;
               end
            end
            S_RD_ADDR: begin
               if (s_arready) r_state <= S_RD_DATA;
            end
            S_RD_DATA: begin
               if (w_r_hs) begin
                  r_cnt <= r_cnt + LEN_WIDTH'(1);
                  if (w_r_bad) r_err <= 1'b1;
                  if (w_final) r_state <= S_IDLE;
               end
            end
            S_WR_ADDR_DATA: begin
               if (st_wdata_pop) r_cnt <= r_cnt + LEN_WIDTH'(1);
               if (w_aw_hs) begin
                  r_state <= (r_w_done || w_w_last) ? S_WR_RESP : S_WR_DATA;
               end else if (w_w_last) begin
                  r_w_done <= 1'b1;
               end
            end
            S_WR_DATA: begin
               if (st_wdata_pop) r_cnt <= r_cnt + LEN_WIDTH'(1);
               if (w_w_last) r_state <= S_WR_RESP;
            end
            S_WR_RESP: begin
               if (s_bvalid) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
